uart_msg_ctrl: RTL and testbench

Bus-master controller that drives the UART's 8-bit register bus to configure it and to stream a short message into its TX data register. It holds a DEPTH-byte message buffer loaded by the host logic. On `start` it writes bytes 0..len-1 to the TX data address, spacing writes by at least BYTE_GAP cycles so the UART TX FIFO, which exposes no full flag, never overflows. It also performs one-shot writes of the UART frequency divider. It sits between application logic and the UART's `wb_*` port.

---
 rtl/uart_msg_ctrl_pkg.sv | 17 +
 rtl/msg_buf.sv | 36 +++
 rtl/uart_msg_ctrl.sv | 182 ++++++++++++++++++
 tb/tb_uart_msg_ctrl.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_msg_ctrl_pkg.sv
// rtl/uart_msg_ctrl_pkg.sv - UART register addresses and controller state encodings
package uart_msg_ctrl_pkg;

    localparam logic [1:0] TX_DATA_ADDR  = 2'd0;
    localparam logic [1:0] RX_DATA_ADDR  = 2'd1;
    localparam logic [1:0] FREQ_DIV_ADDR = 2'd2;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_CFG_REQ  = 3'd1,
        ST_CFG_REL  = 3'd2,
        ST_GAP      = 3'd3,
        ST_SEND_REQ = 3'd4,
        ST_SEND_REL = 3'd5
    } ctrl_state_e;

endpackage

// File: rtl/msg_buf.sv
// rtl/msg_buf.sv - DEPTH x 8 message register file, sync write, async read
module msg_buf #(
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [7:0]               wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [7:0]               rdata
);

    logic [7:0] mem_q [DEPTH];
    logic [7:0] mem_d [DEPTH];

    // Next contents: one byte replaced when the write strobe is up.
    always_comb begin
        mem_d = mem_q;
        if (we) begin
            mem_d[waddr] = wdata;
        end
    end

    // Storage register; reset clears every byte.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_q <= '{default: 8'h00};
        end else begin
            mem_q <= mem_d;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/uart_msg_ctrl.sv
// rtl/uart_msg_ctrl.sv - UART register-bus master for divider setup and paced message transmit
module uart_msg_ctrl
    import uart_msg_ctrl_pkg::*;
#(
    parameter int DEPTH    = 16,
    parameter int BYTE_GAP = 12800
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     load_we,
    input  logic [$clog2(DEPTH)-1:0] load_addr,
    input  logic [7:0]               load_data,
    input  logic                     start,
    input  logic [$clog2(DEPTH):0]   len,
    input  logic                     cfg_we,
    input  logic [7:0]               cfg_divider,
    input  logic                     abort,
    output logic                     busy,
    output logic                     done,
    output logic [$clog2(DEPTH):0]   sent_cnt,
    output logic [1:0]               wb_addr,
    output logic [7:0]               wb_data_out,
    output logic                     wb_we,
    output logic                     wb_stb,
    output logic                     wb_clk,
    input  logic                     wb_ack
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    ctrl_state_e state_q, state_d;
    logic [7:0]  divider_q, divider_d;
    logic [LW-1:0] len_q, len_d;
    logic [LW-1:0] sent_cnt_q, sent_cnt_d;
    logic [AW-1:0] idx_q, idx_d;
    logic [15:0] gap_cnt_q, gap_cnt_d;
    logic        abort_flag_q, abort_flag_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        wb_stb_q, wb_stb_d;
    logic [1:0]  wb_addr_q, wb_addr_d;
    logic [7:0]  wb_data_out_q, wb_data_out_d;
    logic [7:0]  buf_rdata;

    msg_buf #(.DEPTH(DEPTH)) u_msg_buf (
        .clk   (clk),
        .reset (reset),
        .we    (load_we && (state_q == ST_IDLE)),
        .waddr (load_addr),
        .wdata (load_data),
        .raddr (idx_q),
        .rdata (buf_rdata)
    );

    // Next state plus registered bus outputs derived from the state being entered.
    always_comb begin
        state_d      = state_q;
        divider_d    = divider_q;
        len_d        = len_q;
        sent_cnt_d   = sent_cnt_q;
        idx_d        = idx_q;
        abort_flag_d = abort_flag_q;
        done_d       = 1'b0;
        // Pacing counter keeps running in IDLE so the gap also spans separate messages.
        gap_cnt_d    = (gap_cnt_q == 16'd0) ? 16'd0 : gap_cnt_q - 16'd1;

        if (state_q != ST_IDLE && abort) begin
            abort_flag_d = 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                if (cfg_we) begin
                    divider_d = cfg_divider;
                    state_d   = ST_CFG_REQ;
                end else if (start) begin
                    if (len != '0) begin
                        len_d        = (len > LW'(DEPTH)) ? LW'(DEPTH) : len;
                        sent_cnt_d   = '0;
                        idx_d        = '0;
                        abort_flag_d = 1'b0;
                        state_d      = ST_GAP;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            ST_CFG_REQ: begin
                if (wb_ack) begin
                    state_d = ST_CFG_REL;
                end
            end
            ST_CFG_REL: begin
                if (!wb_ack) begin
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            ST_GAP: begin
                if (abort_flag_q) begin
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end else if (gap_cnt_q == 16'd0) begin
                    state_d = ST_SEND_REQ;
                end
            end
            ST_SEND_REQ: begin
                if (wb_ack) begin
                    gap_cnt_d = 16'(BYTE_GAP - 1);
                    state_d   = ST_SEND_REL;
                end
            end
            ST_SEND_REL: begin
                if (!wb_ack) begin
                    idx_d      = idx_q + 1'b1;
                    sent_cnt_d = sent_cnt_q + 1'b1;
                    if (sent_cnt_d == len_q) begin
                        done_d  = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_GAP;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        busy_d        = (state_d != ST_IDLE);
        wb_stb_d      = (state_d == ST_CFG_REQ) || (state_d == ST_SEND_REQ);
        wb_addr_d     = wb_addr_q;
        wb_data_out_d = wb_data_out_q;
        if (state_d == ST_CFG_REQ) begin
            wb_addr_d     = FREQ_DIV_ADDR;
            wb_data_out_d = divider_d;
        end else if (state_d == ST_SEND_REQ) begin
            wb_addr_d     = TX_DATA_ADDR;
            wb_data_out_d = buf_rdata;
        end
    end

    // State and output registers; reset drops the strobe immediately.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            divider_q     <= 8'h00;
            len_q         <= '0;
            sent_cnt_q    <= '0;
            idx_q         <= '0;
            gap_cnt_q     <= 16'd0;
            abort_flag_q  <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            wb_stb_q      <= 1'b0;
            wb_addr_q     <= 2'd0;
            wb_data_out_q <= 8'h00;
        end else begin
            state_q       <= state_d;
            divider_q     <= divider_d;
            len_q         <= len_d;
            sent_cnt_q    <= sent_cnt_d;
            idx_q         <= idx_d;
            gap_cnt_q     <= gap_cnt_d;
            abort_flag_q  <= abort_flag_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            wb_stb_q      <= wb_stb_d;
            wb_addr_q     <= wb_addr_d;
            wb_data_out_q <= wb_data_out_d;
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign sent_cnt    = sent_cnt_q;
    assign wb_stb      = wb_stb_q;
    assign wb_clk      = wb_stb_q;
    assign wb_addr     = wb_addr_q;
    assign wb_data_out = wb_data_out_q;
    assign wb_we       = 1'b0;

endmodule

// File: tb/tb_uart_msg_ctrl.sv
// tb/tb_uart_msg_ctrl.sv - directed self-checking bench for uart_msg_ctrl
module tb_uart_msg_ctrl;

    localparam int DEPTH    = 16;
    localparam int BYTE_GAP = 100;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       load_we = 1'b0;
    logic [3:0] load_addr = 4'd0;
    logic [7:0] load_data = 8'd0;
    logic       start = 1'b0;
    logic [4:0] len = 5'd0;
    logic       cfg_we = 1'b0;
    logic [7:0] cfg_divider = 8'd0;
    logic       abort = 1'b0;
    logic       busy, done, wb_we, wb_stb, wb_clk;
    logic [4:0] sent_cnt;
    logic [1:0] wb_addr;
    logic [7:0] wb_data_out;
    logic       wb_ack;

    int total = 0;
    int bad = 0;

    uart_msg_ctrl #(.DEPTH(DEPTH), .BYTE_GAP(BYTE_GAP)) dut (
        .clk(clk), .reset(reset), .load_we(load_we), .load_addr(load_addr),
        .load_data(load_data), .start(start), .len(len), .cfg_we(cfg_we),
        .cfg_divider(cfg_divider), .abort(abort), .busy(busy), .done(done),
        .sent_cnt(sent_cnt), .wb_addr(wb_addr), .wb_data_out(wb_data_out),
        .wb_we(wb_we), .wb_stb(wb_stb), .wb_clk(wb_clk), .wb_ack(wb_ack)
    );

    always #5 clk = ~clk;

    // Registered-ack slave.
    always @(posedge clk or posedge reset) begin
        if (reset) wb_ack <= 1'b0;
        else       wb_ack <= wb_stb;
    end

    // Bus monitor: strobe log, done count, divider register model.
    int         cyc = 0;
    logic       prev_stb = 1'b0;
    logic [1:0] s_addr[$];
    logic [7:0] s_data[$];
    logic       s_we[$];
    int         s_time[$];
    int         done_cnt = 0;
    int         done_busy_overlap = 0;
    int         clk_diff = 0;
    logic [7:0] div_reg = 8'd0;

    always @(negedge clk) begin
        cyc = cyc + 1;
        if (wb_stb && !prev_stb) begin
            s_addr.push_back(wb_addr);
            s_data.push_back(wb_data_out);
            s_we.push_back(wb_we);
            s_time.push_back(cyc);
            if (wb_addr == 2'd2) div_reg = wb_data_out;
        end
        prev_stb = wb_stb;
        if (done) done_cnt = done_cnt + 1;
        if (done && busy) done_busy_overlap = done_busy_overlap + 1;
        if (wb_clk !== wb_stb) clk_diff = clk_diff + 1;
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic clear_log;
        s_addr.delete();
        s_data.delete();
        s_we.delete();
        s_time.delete();
        done_cnt = 0;
    endtask

    task automatic load_byte(input logic [3:0] a, input logic [7:0] d);
        load_we = 1'b1; load_addr = a; load_data = d;
        tick();
        load_we = 1'b0;
    endtask

    task automatic wait_idle(input int budget, input string name);
        int n = 0;
        while (busy && n < budget) begin
            tick();
            n++;
        end
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("FAIL %s timeout busy=%b required=0", name, busy);
        end
        tick();
    endtask

    task automatic wait_rises(input int count, input int budget, input string name);
        int n = 0;
        int rises = 0;
        logic last = wb_stb;
        while (rises < count && n < budget) begin
            tick();
            n++;
            if (wb_stb && !last) rises++;
            last = wb_stb;
        end
        total++;
        if (rises != count) begin
            bad++;
            $display("FAIL %s strobes=%0d required=%0d", name, rises, count);
        end
    endtask

    task automatic test_reset;
        tick(); tick();
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b exp=0", done); end
        total++; if (sent_cnt !== 5'd0) begin bad++; $display("FAIL reset_sent got=%0d exp=0", sent_cnt); end
        total++; if (wb_stb !== 1'b0 || wb_clk !== 1'b0 || wb_we !== 1'b0) begin
            bad++; $display("FAIL reset_strobe stb=%b clk=%b we=%b exp=0", wb_stb, wb_clk, wb_we); end
        total++; if (wb_addr !== 2'd0 || wb_data_out !== 8'd0) begin
            bad++; $display("FAIL reset_bus addr=%0d data=%0h exp=0", wb_addr, wb_data_out); end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_cfg;
        clear_log();
        cfg_we = 1'b1; cfg_divider = 8'd39;
        tick();
        cfg_we = 1'b0;
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL cfg_busy got=%b exp=1", busy); end
        wait_idle(100, "cfg_idle");
        total++; if (s_addr.size() != 1) begin bad++; $display("FAIL cfg_strobes got=%0d exp=1", s_addr.size()); end
        else begin
            total++; if (s_addr[0] !== 2'd2 || s_data[0] !== 8'd39 || s_we[0] !== 1'b0) begin
                bad++; $display("FAIL cfg_bus addr=%0d data=%0d we=%b exp=2/39/0", s_addr[0], s_data[0], s_we[0]); end
        end
        total++; if (done_cnt != 1) begin bad++; $display("FAIL cfg_done got=%0d exp=1", done_cnt); end
        total++; if (div_reg !== 8'd39) begin bad++; $display("FAIL cfg_divreg got=%0d exp=39", div_reg); end
    endtask

    task automatic test_message;
        logic [7:0] hello [5];
        hello[0] = 8'h48; hello[1] = 8'h45; hello[2] = 8'h4C; hello[3] = 8'h4C; hello[4] = 8'h4F;
        for (int i = 0; i < 5; i++) load_byte(4'(i), hello[i]);
        clear_log();
        start = 1'b1; len = 5'd5;
        tick();
        start = 1'b0;
        total++; if (busy !== 1'b1 || wb_stb !== 1'b0) begin
            bad++; $display("FAIL msg_lat1 busy=%b stb=%b exp=1/0", busy, wb_stb); end
        tick();
        total++; if (wb_stb !== 1'b1) begin bad++; $display("FAIL msg_lat2 stb=%b exp=1", wb_stb); end
        wait_idle(1000, "msg_idle");
        total++; if (s_addr.size() != 5) begin bad++; $display("FAIL msg_strobes got=%0d exp=5", s_addr.size()); end
        else begin
            for (int i = 0; i < 5; i++) begin
                total++; if (s_addr[i] !== 2'd0 || s_data[i] !== hello[i]) begin
                    bad++; $display("FAIL msg_byte%0d addr=%0d data=%0h exp=0/%0h", i, s_addr[i], s_data[i], hello[i]); end
            end
            for (int i = 1; i < 5; i++) begin
                total++; if (s_time[i] - s_time[i-1] < BYTE_GAP) begin
                    bad++; $display("FAIL msg_gap%0d got=%0d exp>=%0d", i, s_time[i] - s_time[i-1], BYTE_GAP); end
            end
        end
        total++; if (sent_cnt !== 5'd5) begin bad++; $display("FAIL msg_sent got=%0d exp=5", sent_cnt); end
        total++; if (done_cnt != 1) begin bad++; $display("FAIL msg_done got=%0d exp=1", done_cnt); end
    endtask

    task automatic test_abort;
        for (int i = 0; i < 8; i++) load_byte(4'(i), 8'h10 + 8'(i));
        clear_log();
        start = 1'b1; len = 5'd8;
        tick();
        start = 1'b0;
        wait_rises(3, 1000, "abort_wait3");
        abort = 1'b1;
        tick();
        abort = 1'b0;
        wait_idle(1000, "abort_idle");
        total++; if (s_addr.size() != 3) begin bad++; $display("FAIL abort_strobes got=%0d exp=3", s_addr.size()); end
        else begin
            total++; if (s_data[2] !== 8'h12) begin bad++; $display("FAIL abort_byte3 got=%0h exp=12", s_data[2]); end
        end
        total++; if (sent_cnt !== 5'd3) begin bad++; $display("FAIL abort_sent got=%0d exp=3", sent_cnt); end
        total++; if (done_cnt != 1) begin bad++; $display("FAIL abort_done got=%0d exp=1", done_cnt); end
    endtask

    task automatic test_len0;
        clear_log();
        start = 1'b1; len = 5'd0;
        tick();
        start = 1'b0;
        total++; if (done !== 1'b1 || busy !== 1'b0) begin
            bad++; $display("FAIL len0_done done=%b busy=%b exp=1/0", done, busy); end
        tick();
        total++; if (done !== 1'b0) begin bad++; $display("FAIL len0_pulse done=%b exp=0", done); end
        for (int i = 0; i < 5; i++) tick();
        total++; if (s_addr.size() != 0) begin bad++; $display("FAIL len0_strobes got=%0d exp=0", s_addr.size()); end
    endtask

    task automatic test_clamp;
        for (int i = 0; i < 16; i++) load_byte(4'(i), 8'hA0 + 8'(i));
        clear_log();
        start = 1'b1; len = 5'd31;
        tick();
        start = 1'b0;
        wait_idle(3000, "clamp_idle");
        total++; if (s_addr.size() != 16) begin bad++; $display("FAIL clamp_strobes got=%0d exp=16", s_addr.size()); end
        else begin
            total++; if (s_data[15] !== 8'hAF) begin bad++; $display("FAIL clamp_last got=%0h exp=af", s_data[15]); end
        end
        total++; if (sent_cnt !== 5'd16) begin bad++; $display("FAIL clamp_sent got=%0d exp=16", sent_cnt); end
    endtask

    task automatic test_cfg_start_same;
        clear_log();
        cfg_we = 1'b1; cfg_divider = 8'd7; start = 1'b1; len = 5'd2;
        tick();
        cfg_we = 1'b0; start = 1'b0;
        wait_idle(100, "same_idle");
        for (int i = 0; i < 300; i++) tick();
        total++; if (s_addr.size() != 1) begin bad++; $display("FAIL same_strobes got=%0d exp=1", s_addr.size()); end
        else begin
            total++; if (s_addr[0] !== 2'd2 || s_data[0] !== 8'd7) begin
                bad++; $display("FAIL same_bus addr=%0d data=%0d exp=2/7", s_addr[0], s_data[0]); end
        end
        total++; if (done_cnt != 1) begin bad++; $display("FAIL same_done got=%0d exp=1", done_cnt); end
    endtask

    task automatic test_lockout;
        clear_log();
        start = 1'b1; len = 5'd2;
        tick();
        start = 1'b0;
        wait_rises(1, 500, "lock_wait1");
        load_we = 1'b1; load_addr = 4'd0; load_data = 8'h55;
        start = 1'b1; len = 5'd5; cfg_we = 1'b1; cfg_divider = 8'd99;
        tick();
        load_we = 1'b0; start = 1'b0; cfg_we = 1'b0;
        wait_idle(1000, "lock_idle");
        for (int i = 0; i < 300; i++) tick();
        total++; if (s_addr.size() != 2) begin bad++; $display("FAIL lock_strobes got=%0d exp=2", s_addr.size()); end
        total++; if (div_reg !== 8'd7) begin bad++; $display("FAIL lock_div got=%0d exp=7", div_reg); end
        clear_log();
        start = 1'b1; len = 5'd1;
        tick();
        start = 1'b0;
        wait_idle(500, "lock_idle2");
        total++; if (s_data.size() != 1) begin bad++; $display("FAIL lock_resend got=%0d exp=1", s_data.size()); end
        else begin
            total++; if (s_data[0] !== 8'hA0) begin bad++; $display("FAIL lock_buf0 got=%0h exp=a0", s_data[0]); end
        end
    endtask

    task automatic test_reset_mid;
        clear_log();
        start = 1'b1; len = 5'd3;
        tick();
        start = 1'b0;
        wait_rises(1, 500, "rst_wait");
        #2;
        reset = 1'b1;
        #1;
        total++; if (wb_stb !== 1'b0 || busy !== 1'b0) begin
            bad++; $display("FAIL rst_async stb=%b busy=%b exp=0/0", wb_stb, busy); end
        total++; if (sent_cnt !== 5'd0) begin bad++; $display("FAIL rst_sent got=%0d exp=0", sent_cnt); end
        tick();
        reset = 1'b0;
        tick();
        clear_log();
        start = 1'b1; len = 5'd1;
        tick();
        start = 1'b0;
        wait_idle(100, "rst_idle");
        total++; if (s_data.size() != 1) begin bad++; $display("FAIL rst_strobes got=%0d exp=1", s_data.size()); end
        else begin
            total++; if (s_data[0] !== 8'h00) begin bad++; $display("FAIL rst_buf got=%0h exp=0", s_data[0]); end
        end
    endtask

    task automatic test_invariants;
        total++; if (done_busy_overlap != 0) begin
            bad++; $display("FAIL done_busy_overlap got=%0d exp=0", done_busy_overlap); end
        total++; if (clk_diff != 0) begin bad++; $display("FAIL wbclk_vs_stb got=%0d exp=0", clk_diff); end
    endtask

    initial begin
        test_reset();
        test_cfg();
        test_message();
        test_abort();
        test_len0();
        test_clamp();
        test_cfg_start_same();
        test_lockout();
        test_reset_mid();
        test_invariants();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
